// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit carry-lookahead slice over WIDTH/4 cycles, LSB nibble first.
// Define NIBBLE_ADDER_OVF_EN to add a registered two's-complement overflow output (ovf).

module nibble_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_p,
  output logic       o_g
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p    = i_a ^ i_b;
  assign w_g    = i_a & i_b;
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_sum  = w_p ^ w_c;
  assign o_p    = &w_p;
  assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_badWidth
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aReg;
  logic [WIDTH-1:0] r_bReg;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [3:0]       w_sliceSum;
  logic             w_sliceP;
  logic             w_sliceG;
  logic             w_carryNext;
  logic             w_accept;
  logic             w_lastNib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Select the operand nibble addressed by the current index for the shared slice.
  always_comb begin
    w_aNib = '0;
    w_bNib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_aNib = r_aReg[4*i +: 4];
        w_bNib = r_bReg[4*i +: 4];
      end
    end
  end

  nibble_cla4 u_slice (
    .i_a   (w_aNib),
    .i_b   (w_bNib),
    .i_cin (r_carry),
    .o_sum (w_sliceSum),
    .o_p   (w_sliceP),
    .o_g   (w_sliceG)
  );

  assign w_carryNext = w_sliceG | (w_sliceP & r_carry);
  assign w_accept    = in_valid & in_ready;
  assign w_lastNib   = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aReg  <= '0;
      r_bReg  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_aReg  <= a;
      r_bReg  <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_carry <= w_carryNext;
      for (int i = 0; i < NIB; i++) begin
        if (r_idx == IDXW'(i)) begin
          r_sum[4*i +: 4] <= w_sliceSum;
        end
      end
      if (w_lastNib) begin
        r_cout <= w_carryNext;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDXW'(1);
      end
    end
  end

`ifdef NIBBLE_ADDER_OVF_EN
  logic r_ovf;

  // The final slice produces sum MSB, so overflow is judged on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_lastNib) begin
      r_ovf <= (r_aReg[WIDTH-1] == r_bReg[WIDTH-1]) && (w_sliceSum[3] != r_aReg[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=4 instances).
// Define NIBBLE_ADDER_OVF_EN to also exercise the overflow output.

module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rstN;
  logic             inValid, inReady, outValid, outReady, cinIn, coutOut, busyOut;
  logic [WIDTH-1:0] aIn, bIn, sumOut;
  logic             inValid4, inReady4, outValid4, outReady4, cinIn4, coutOut4, busyOut4;
  logic [3:0]       aIn4, bIn4, sumOut4;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovfOut, ovfOut4;
`endif

  result_t expQueue[$];
  int totalCount = 0;
  int badCount   = 0;
  int cycleCount = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut16 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .a(aIn), .b(bIn), .cin(cinIn), .out_valid(outValid), .out_ready(outReady),
    .sum(sumOut), .cout(coutOut), .busy(busyOut)
`ifdef NIBBLE_ADDER_OVF_EN
    , .ovf(ovfOut)
`endif
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid4), .in_ready(inReady4),
    .a(aIn4), .b(bIn4), .cin(cinIn4), .out_valid(outValid4), .out_ready(outReady4),
    .sum(sumOut4), .cout(coutOut4), .busy(busyOut4)
`ifdef NIBBLE_ADDER_OVF_EN
    , .ovf(ovfOut4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) else begin
      badCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal, input logic cinVal);
    logic [WIDTH:0] full;
    result_t r;
    full   = {1'b0, aVal} + {1'b0, bVal} + {{WIDTH{1'b0}}, cinVal};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (aVal[WIDTH-1] == bVal[WIDTH-1]) && (full[WIDTH-1] != aVal[WIDTH-1]);
    expQueue.push_back(r);
  endtask

  // Present operands at a falling edge and hold them until the accepting rising edge has passed.
  task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal, input logic cinVal);
    int n;
    aIn = aVal; bIn = bVal; cinIn = cinVal; inValid = 1'b1;
    n = 0;
    while (inReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept ready", {31'b0, inReady}, 32'd1);
    pushExpected(aVal, bVal, cinVal);
    @(negedge clk);
    inValid = 1'b0;
    aIn = ~aVal; bIn = ~bVal; cinIn = ~cinVal;
  endtask

  task automatic waitResult(input string tag, output int edges);
    edges = 0;
    while (outValid !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      checkOutput({tag, " busy"}, {31'b0, busyOut}, 32'd1);
    end
  endtask

  task automatic popCompare(input string tag);
    result_t r;
    if (expQueue.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      r = expQueue.pop_front();
      checkOutput({tag, " sum"}, {16'b0, sumOut}, {16'b0, r.sum});
      checkOutput({tag, " cout"}, {31'b0, coutOut}, {31'b0, r.cout});
`ifdef NIBBLE_ADDER_OVF_EN
      checkOutput({tag, " ovf"}, {31'b0, ovfOut}, {31'b0, r.ovf});
`endif
    end
  endtask

  task automatic handshake(input string tag);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, " out_valid drop"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, " in_ready back"}, {31'b0, inReady}, 32'd1);
  endtask

  task automatic runOne(input string tag, input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal, input logic cinVal);
    int edges;
    applyStimulus(aVal, bVal, cinVal);
    waitResult(tag, edges);
    checkOutput({tag, " latency"}, edges, NIB);
    popCompare(tag);
    handshake(tag);
  endtask

  initial begin
    int edges;
    int accepted;
    int popped;
    int lastAccept;

    rstN = 1'b0;
    inValid = 1'b0; outReady = 1'b0; aIn = '0; bIn = '0; cinIn = 1'b0;
    inValid4 = 1'b0; outReady4 = 1'b0; aIn4 = '0; bIn4 = '0; cinIn4 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset busy", {31'b0, busyOut}, 32'd0);
    checkOutput("reset sum", {16'b0, sumOut}, 32'd0);
    checkOutput("reset cout", {31'b0, coutOut}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] wrap-around carry 0xFFFF+0x0001");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("ffff busy T0", {31'b0, busyOut}, 32'd1);
    waitResult("ffff", edges);
    checkOutput("ffff latency", edges, NIB);
    checkOutput("ffff sum const", {16'b0, sumOut}, 32'h0000);
    checkOutput("ffff cout const", {31'b0, coutOut}, 32'd1);
    popCompare("ffff");
    handshake("ffff");

    $display("[TB] directed sums");
    runOne("1234+4321+1", 16'h1234, 16'h4321, 1'b1);
    runOne("0f0f+00f1", 16'h0F0F, 16'h00F1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    waitResult("bp", edges);
    checkOutput("bp latency", edges, NIB);
    inValid = 1'b1; aIn = 16'h0F00; bIn = 16'h00F0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp hold sum", {16'b0, sumOut}, {16'b0, expQueue[0].sum});
      checkOutput("bp hold cout", {31'b0, coutOut}, {31'b0, expQueue[0].cout});
      checkOutput("bp hold out_valid", {31'b0, outValid}, 32'd1);
      checkOutput("bp hold in_ready", {31'b0, inReady}, 32'd0);
    end
    popCompare("bp");
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0; outReady = 1'b0;
    checkOutput("bp out_valid drop", {31'b0, outValid}, 32'd0);
    checkOutput("bp in_ready back", {31'b0, inReady}, 32'd1);
    checkOutput("bp no turnaround accept", {31'b0, busyOut}, 32'd0);
    @(negedge clk);
    checkOutput("bp stays idle", {31'b0, busyOut}, 32'd0);

    $display("[TB] reset during RUN");
    applyStimulus(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("abort out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("abort sum", {16'b0, sumOut}, 32'd0);
    checkOutput("abort busy", {31'b0, busyOut}, 32'd0);
    expQueue.delete();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    waitResult("post-abort", edges);
    checkOutput("post-abort latency", edges, NIB);
    checkOutput("post-abort sum const", {16'b0, sumOut}, 32'h0002);
    popCompare("post-abort");
    handshake("post-abort");

    $display("[TB] back-to-back random");
    accepted = 0; popped = 0; lastAccept = 0;
    inValid = 1'b1; outReady = 1'b1;
    for (int cyc = 0; cyc < 800 && popped < 100; cyc++) begin
      if (outValid === 1'b1) begin
        popCompare("b2b");
        popped++;
      end
      if (inReady === 1'b1 && accepted < 100) begin
        aIn = WIDTH'($urandom); bIn = WIDTH'($urandom); cinIn = 1'($urandom_range(0, 1));
        pushExpected(aIn, bIn, cinIn);
        if (accepted > 0) checkOutput("b2b spacing", cycleCount - lastAccept, NIB + 2);
        lastAccept = cycleCount;
        accepted++;
      end else begin
        aIn = WIDTH'($urandom); bIn = WIDTH'($urandom); cinIn = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    inValid = 1'b0; outReady = 1'b0;
    checkOutput("b2b results", popped, 100);

    $display("[TB] WIDTH=4 instance");
    aIn4 = 4'hF; bIn4 = 4'h1; cinIn4 = 1'b0; inValid4 = 1'b1;
    checkOutput("w4 in_ready", {31'b0, inReady4}, 32'd1);
    @(negedge clk);
    inValid4 = 1'b0; aIn4 = 4'h0;
    checkOutput("w4 busy", {31'b0, busyOut4}, 32'd1);
    checkOutput("w4 not yet valid", {31'b0, outValid4}, 32'd0);
    @(negedge clk);
    checkOutput("w4 out_valid", {31'b0, outValid4}, 32'd1);
    checkOutput("w4 sum", {28'b0, sumOut4}, 32'h0);
    checkOutput("w4 cout", {31'b0, coutOut4}, 32'd1);
    outReady4 = 1'b1;
    @(negedge clk);
    outReady4 = 1'b0;
    checkOutput("w4 out_valid drop", {31'b0, outValid4}, 32'd0);

`ifdef NIBBLE_ADDER_OVF_EN
    $display("[TB] overflow flag");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitResult("ovf1", edges);
    checkOutput("ovf1 const", {31'b0, ovfOut}, 32'd1);
    popCompare("ovf1");
    handshake("ovf1");
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitResult("ovf2", edges);
    checkOutput("ovf2 const", {31'b0, ovfOut}, 32'd1);
    checkOutput("ovf2 cout const", {31'b0, coutOut}, 32'd1);
    popCompare("ovf2");
    handshake("ovf2");
    applyStimulus(16'h1234, 16'h0001, 1'b0);
    waitResult("ovf3", edges);
    checkOutput("ovf3 const", {31'b0, ovfOut}, 32'd0);
    popCompare("ovf3");
    handshake("ovf3");
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by reusing a single 4-bit carry-lookahead slice over WIDTH/4 consecutive cycles, least-significant nibble first.
- The slice returns the nibble sum plus group propagate p and generate g; the controller owns the inter-nibble carry register.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output). It trades latency for area against a full-width CLA tree.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIB, WIDTH/4, derived nibble count. Not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  requester presents operands.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result sum, registered.
- cout  output  1  carry out of the top nibble, registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0. Reset asserted mid-RUN or mid-DONE aborts the operation and drops the result; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready on a clock edge, latch a, b, cin into operand registers, set carry=cin and index=0, go to RUN.
  - RUN: in_ready=0. Each cycle, drive the slice with a_reg[4k+3:4k], b_reg[4k+3:4k] and carry. On the edge, write the slice sum into sum[4k+3:4k] and update carry <= g | (p & carry).
    - If k==NIB-1, go to DONE and set cout to the same carry value.
    - Otherwise index=k+1.
  - DONE: out_valid=1, in_ready=0. sum and cout are held stable. When out_valid&out_ready on an edge, out_valid=0 and the state returns to IDLE.
- Input changes on a and b after acceptance have no effect, because the operands are registered.
- Latency: out_valid rises exactly NIB clock edges after the accepting edge (4 for WIDTH=16, 1 for WIDTH=4).
- Throughput: one result per NIB+2 cycles at best. There is no same-cycle turnaround: the DONE→IDLE edge does not accept new operands, and in_ready returns high in the following cycle.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum bits of not-yet-processed nibbles keep the previous result during RUN. Consumers must only sample sum while out_valid is high.
- Arithmetic is unsigned modulo 2^WIDTH with carry out on cout, so {cout,sum} = a + b + cin exactly.
- Index counter width is clog2(NIB), minimum 1 bit. It wraps to 0 on leaving RUN.

Optional Feature:
- Macro: NIBBLE_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, reset 0), valid with out_valid.
  - ovf is the two's-complement overflow: a_reg[WIDTH-1]==b_reg[WIDTH-1] and sum[WIDTH-1]!=a_reg[WIDTH-1]. It is computed on the final RUN edge.
- When undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Reset then WIDTH=16: a=0xFFFF, b=0x0001, cin=0 accepted at edge T0 → out_valid high after edge T4, sum=0x0000, cout=1; busy high T1..T4.
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. Also a=0x0F0F, b=0x00F1, cin=0 → sum=0x1000, cout=0, which checks carry ripple across nibbles 0–2.
- Backpressure: after result valid, hold out_ready=0 for 5 cycles → sum, cout and out_valid held constant, in_ready=0, and new in_valid is ignored. Raise out_ready → out_valid low next cycle, in_ready high the cycle after.
- Reset mid-RUN: accept a=0xAAAA, b=0x5555, pulse rst_n low after 2 RUN edges → immediately in_ready=1, out_valid=0, sum=0. A following transaction 0x0001+0x0001 gives sum=0x0002.
- Back-to-back with in_valid and out_ready held high and random operands over 100 transactions: every result equals a+b+cin, and the accept-to-accept spacing is exactly 6 cycles. WIDTH=4 instance: a=0xF, b=0x1 → sum=0x0, cout=1 one edge after accept.
- With NIBBLE_ADDER_OVF_EN: 0x7FFF+0x0001 → ovf=1; 0x8000+0x8000 → ovf=1, cout=1; 0x1234+0x0001 → ovf=0.
